// File: rtl/toggle_mon_pkg.sv
// Shared types for the toggle run-length monitor.
// Optional total counter: TOGGLE_MON_TOTAL_EN.
package toggle_mon_pkg;

    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_PEND
    } st_e;

    typedef struct packed {
        logic                 level;
        logic [CNT_W_DEF-1:0] len;
    } run_rec_t;

endpackage

// File: rtl/toggle_run_monitor_sat_counter.sv
// Saturating up-counter with synchronous load-to-1 and async clear.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;
    logic         w_full;

    assign w_full = &r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= W'(1);
        end else if (i_inc && !w_full) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/toggle_run_monitor.sv
// Run-length monitor of the toggle stage output bit.
// Define TOGGLE_MON_TOTAL_EN to add the total_toggles counter.
module toggle_run_monitor
    import toggle_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_level,
    output logic [CNT_W-1:0] out_len
`ifdef TOGGLE_MON_TOTAL_EN
    ,
    output logic             overrun,
    output logic [7:0]       total_toggles
`else
    ,
    output logic             overrun
`endif
);

    typedef struct packed {
        logic             level;
        logic [CNT_W-1:0] len;
    } rec_t;

    st_e        r_state;
    st_e        w_next;
    logic       r_a_q;
    logic       r_valid;
    logic       r_ovr;
    rec_t       r_rec;
    logic [CNT_W-1:0] w_cnt;
    logic       w_run_end;
    logic       w_cnt_load;
    logic       w_load;
    logic       w_clear;
    logic       w_drop;

    assign w_run_end  = (r_state != ST_INIT) && (a_in != r_a_q);
    assign w_cnt_load = (r_state == ST_INIT) || w_run_end;

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_cnt_load),
        .i_inc  (1'b1),
        .o_cnt  (w_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_INIT: w_next = ST_RUN;
            ST_RUN:  if (w_run_end) w_next = ST_PEND;
            ST_PEND: if (out_ready && !w_run_end) w_next = ST_RUN;
            default: w_next = ST_INIT;
        endcase
    end

    // A run end while pending is kept only if the pending one is taken.
    always_comb begin
        w_load  = 1'b0;
        w_clear = 1'b0;
        w_drop  = 1'b0;
        unique case (r_state)
            ST_RUN: w_load = w_run_end;
            ST_PEND: begin
                w_load  = out_ready && w_run_end;
                w_clear = out_ready && !w_run_end;
                w_drop  = !out_ready && w_run_end;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_q   <= 1'b0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_rec   <= '0;
        end else begin
            r_a_q <= a_in;
            if (w_load) begin
                r_rec   <= '{level: r_a_q, len: w_cnt};
                r_valid <= 1'b1;
            end else if (w_clear) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_level = r_rec.level;
    assign out_len   = r_rec.len;
    assign overrun   = r_ovr;

`ifdef TOGGLE_MON_TOTAL_EN
    logic [7:0] r_total;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_total <= '0;
        end else if (w_run_end) begin
            r_total <= r_total + 8'd1;
        end
    end

    assign total_toggles = r_total;
`endif

endmodule

// File: tb/tb_toggle_run_monitor.sv
// Directed bench for toggle_run_monitor.
// Exercises TOGGLE_MON_TOTAL_EN when the macro is defined.
module tb_toggle_run_monitor;
    import toggle_mon_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       a_in = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic       out_level;
    logic [3:0] out_len;
    logic       overrun;
`ifdef TOGGLE_MON_TOTAL_EN
    logic [7:0] total_toggles;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    toggle_run_monitor #(.CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_in      (a_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_level (out_level),
        .out_len   (out_len)
`ifdef TOGGLE_MON_TOTAL_EN
        ,
        .overrun   (overrun),
        .total_toggles (total_toggles)
`else
        ,
        .overrun   (overrun)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic a, input logic rdy);
        a_in      = a;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_rec(input string tag, input run_rec_t exp);
        check({tag, ".valid"}, int'(out_valid), 1);
        check({tag, ".level"}, int'(out_level), int'(exp.level));
        check({tag, ".len"}, int'(out_len), int'(exp.len));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        // Reset held with a_in toggling
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(1'(i), 1'b1);
        check("rst.valid", int'(out_valid), 0);
        check("rst.level", int'(out_level), 0);
        check("rst.len", int'(out_len), 0);
        check("rst.ovr", int'(overrun), 0);
`ifdef TOGGLE_MON_TOTAL_EN
        check("rst.total", int'(total_toggles), 0);
`endif
        reset = 1'b1;
        step(1'b1, 1'b1);
        check("init.novalid", int'(out_valid), 0);

        // Basic runs: 1 x3, 0 x2, then 1
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("basic.pre", int'(out_valid), 0);
        step(1'b0, 1'b1);
        check_rec("basic.r1", '{level: 1'b1, len: 4'd3});
        step(1'b0, 1'b1);
        check("basic.drop", int'(out_valid), 0);
        step(1'b1, 1'b1);
        check_rec("basic.r2", '{level: 1'b0, len: 4'd2});
        step(1'b1, 1'b1);
        check("basic.idle", int'(out_valid), 0);

        // Saturation at 15
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check_rec("sat", '{level: 1'b1, len: 4'd15});

        // Minimum run length, back-to-back with ready tied high
        do_reset();
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check_rec("min.r1", '{level: 1'b0, len: 4'd1});
        step(1'b0, 1'b1);
        check_rec("min.r2", '{level: 1'b1, len: 4'd1});

        // Overrun: pattern 1,1,0,0,1 with ready low
        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_rec("ovr.r1", '{level: 1'b1, len: 4'd2});
        step(1'b0, 1'b0);
        check_rec("ovr.hold", '{level: 1'b1, len: 4'd2});
        check("ovr.flag0", int'(overrun), 0);
        step(1'b1, 1'b0);
        check_rec("ovr.keep", '{level: 1'b1, len: 4'd2});
        check("ovr.flag1", int'(overrun), 1);
        step(1'b1, 1'b1);
        check("ovr.accept", int'(out_valid), 0);
        check("ovr.sticky", int'(overrun), 1);

        // Simultaneous accept and new record
        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_rec("sim.r1", '{level: 1'b1, len: 4'd2});
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        check_rec("sim.r2", '{level: 1'b0, len: 4'd2});
        check("sim.noovr", int'(overrun), 0);

        // Asynchronous reset with a record pending
        step(1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("arst.valid", int'(out_valid), 0);
        check("arst.len", int'(out_len), 0);
        reset = 1'b1;

`ifdef TOGGLE_MON_TOTAL_EN
        do_reset();
        step(1'b0, 1'b1);
        for (int i = 0; i < 300; i++) step(1'(~i[0]), 1'b1);
        check("total", int'(total_toggles), 44);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/toggle_run_monitor.md
# toggle_run_monitor

Downstream consumer of the x-XOR-y toggle flip-flop stage. It samples the stage's state output every clock and measures how many cycles each level is held (run length). Each completed run is emitted as a record {level, length} on a valid/ready output port, with a sticky overrun flag when records are lost. It turns the toggle stage's bit stream into run-length events for logging or for a downstream checker.

## Interface
- CNT_W, 4, width of the run-length counter and out_len; minimum 2.
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- a_in  input  1  state bit A from the toggle stage, synchronous to clk.
- out_ready  input  1  consumer accepts the record on a rising edge where out_valid=1.
- out_valid  output  1  a run record is pending.
- out_level  output  1  level of the completed run.
- out_len  output  CNT_W  cycles the level was held, saturating at 2^CNT_W-1.
- overrun  output  1  sticky; a completed run was dropped.
- total_toggles  output  8  present only with TOGGLE_MON_TOTAL_EN.

## Operation
- Internal state:
  - a_q, the last sampled level.
  - run_cnt[CNT_W-1:0].
  - FSM with states ST_INIT, ST_RUN, ST_PEND.
- Reset values: state=ST_INIT; a_q=0, run_cnt=0, out_valid=0, out_level=0, out_len=0, overrun=0, total_toggles=0.
- ST_INIT: the first edge after reset release sets a_q<=a_in and run_cnt<=1, then goes to ST_RUN. No record is produced.
- Same level (a_in==a_q): run_cnt<=run_cnt+1, saturating at all-ones and holding there.
- Run end (a_in!=a_q), in ST_RUN or ST_PEND:
  - The completed record is {a_q, run_cnt}.
  - a_q<=a_in and run_cnt<=1.
- Record load in ST_RUN: out_level/out_len <= record, out_valid<=1, go to ST_PEND.
- ST_PEND with out_ready=1 and no run end: out_valid<=0, go to ST_RUN.
- ST_PEND with out_ready=1 and a run end on the same edge: the new record replaces the accepted one. out_valid stays 1; stay in ST_PEND.
- ST_PEND with out_ready=0 and a run end:
  - The new record is dropped and the pending record is held unchanged.
  - overrun<=1, cleared only by reset.
- Output stability: out_level and out_len are stable while out_valid=1 and not accepted.
- out_valid does not depend combinationally on out_ready; all outputs are registered.

## Timing
- a_in changing before edge N is a run end detected at edge N. out_valid rises after edge N, so latency is 1 clock.
- Minimum run length reported is 1, which occurs when a_in toggles on consecutive edges.
- Back-to-back records with out_ready tied to 1: out_valid stays high and out_len/out_level update each run end.
- Reset asserted mid-run or with a record pending: all state clears asynchronously and the pending record is lost. After release the block restarts in ST_INIT.
- A run still in progress when reset asserts is never reported.

## Configuration
- TOGGLE_MON_TOTAL_EN defined: adds the total_toggles output, an 8-bit counter.
  - Increments on every run end (transition of a_in relative to a_q), including dropped ones.
  - Wraps 255 to 0. Reset value 0.
- TOGGLE_MON_TOTAL_EN undefined: no total_toggles port and no counter logic. All other behaviour is identical.

## Structure
- Package toggle_mon_pkg holds:
  - state enum st_e {ST_INIT, ST_RUN, ST_PEND}.
  - default CNT_W constant.
  - packed record typedef run_rec_t {level, len}.
- Sub-module sat_counter (parameter W) contains the run_cnt saturating increment with synchronous load-to-1 and asynchronous clear.
- Top level holds the FSM, output register, overrun flag and the optional total counter.

## Test plan
- Reset: hold reset=0 with a_in toggling. Required: all outputs 0, no out_valid. After release the first edge yields no record.
- Basic runs: out_ready=1, a_in=1 for 3 edges then 0 for 2 edges then 1. Required: records {1,3} then {0,2}, each out_valid one cycle after the change.
- Saturation: CNT_W=4, a_in held 1 for 20 edges then 0. Required: record {1,15}.
- Overrun: out_ready=0, a_in pattern 1,1,0,0,1. Required:
  - first record {1,2} is held;
  - second run end sets overrun=1;
  - raising out_ready accepts {1,2} and out_valid drops.
- Simultaneous accept and load: a record is pending, then out_ready=1 on the same edge as a run end. Required: out_valid stays 1 with the new record, no overrun.
- With TOGGLE_MON_TOTAL_EN: 300 single-cycle toggles. Required: total_toggles = 300 mod 256 = 44 (the first ST_INIT sample is not counted).
